// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the multi-player reaction timer.
package reaction_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_FOUL = 3'd4
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One right-shifting Galois step; a non-zero seed never reaches zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/bcd_counter_chain.sv
// Ripple-carry chain of BCD digits; wraps 9->0 per digit, saturation is the parent's job.
module bcd_counter_chain
    import reaction_timer_pkg::*;
#(
    parameter int DIGITS = 6
) (
    input  logic                clk50M,
    input  logic                rst,
    input  logic                clear,
    input  logic                inc,
    output logic [4*DIGITS-1:0] value,
    output logic                all_nines
);

    logic [DIGITS-1:0] carry;
    logic [DIGITS-1:0] is_nine;

    assign carry[0] = inc;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_t digit_reg;

            assign is_nine[gi]       = (digit_reg == 4'd9);
            assign value[4*gi +: 4]  = digit_reg;

            // Higher digits only advance when every lower digit is rolling over.
            if (gi < DIGITS - 1) begin : g_carry
                assign carry[gi+1] = carry[gi] & is_nine[gi];
            end

            always_ff @(posedge clk50M) begin
                if (rst || clear) begin
                    digit_reg <= 4'd0;
                end else if (carry[gi]) begin
                    digit_reg <= is_nine[gi] ? 4'd0 : digit_reg + 4'd1;
                end
            end
        end
    endgenerate

    assign all_nines = &is_nine;

endmodule

// File: rtl/reaction_timer_multi.sv
// Multi-player reaction timer: random foreperiod, BCD ms count, false-start and overflow.
// Optional best-time tracking is enabled by defining REACTION_BEST_TIME_EN.
module reaction_timer_multi
    import reaction_timer_pkg::*;
#(
    parameter int DIGITS    = 6,
    parameter int PLAYERS   = 2,
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 1000,
    parameter int MIN_DELAY = 1000,
    parameter int RAND_BITS = 12,
    localparam int WW       = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
    input  logic                clk50M,
    input  logic                rst,
    input  logic                start,
    input  logic [PLAYERS-1:0]  stop,
    output logic                led_go,
    output logic [4*DIGITS-1:0] time_bcd,
    output logic [WW-1:0]       winner,
    output logic                false_start,
    output logic                overflow,
`ifdef REACTION_BEST_TIME_EN
    output logic [4*DIGITS-1:0] best_bcd,
`endif
    output logic                busy
);

    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DELAY_W = $clog2(MIN_DELAY + 2**RAND_BITS);

    state_t               state_reg, state_next;
    logic [15:0]          lfsr_reg;
    logic [DIV_W-1:0]     div_reg;
    logic [DELAY_W-1:0]   delay_reg;
    logic [WW-1:0]        winner_reg;
    logic                 overflow_reg;
    logic [PLAYERS-1:0]   sync1_reg, sync2_reg, sync3_reg;

    logic                 tick;
    logic [PLAYERS-1:0]   stop_edge;
    logic                 any_stop;
    logic                 load_round;
    logic                 dec_delay;
    logic                 count_inc;
    logic                 capture_winner;
    logic                 set_overflow;
    logic [4*DIGITS-1:0]  count_value;
    logic                 count_all_nines;

    function automatic logic [WW-1:0] lowest_index(input logic [PLAYERS-1:0] v);
        logic [WW-1:0] idx;
        idx = '0;
        for (int i = PLAYERS - 1; i >= 0; i--) begin
            if (v[i]) idx = WW'(i);
        end
        return idx;
    endfunction

    // Rising edge of the synchronised level: a button held across a state entry stays silent.
    assign stop_edge = sync2_reg & ~sync3_reg;
    assign any_stop  = |stop_edge;
    assign tick      = (div_reg == DIV_W'(DIV - 1));

    always_comb begin
        state_next     = state_reg;
        load_round     = 1'b0;
        dec_delay      = 1'b0;
        count_inc      = 1'b0;
        capture_winner = 1'b0;
        set_overflow   = 1'b0;
        led_go         = (state_reg == ST_RUN);
        busy           = (state_reg == ST_WAIT) || (state_reg == ST_RUN);
        false_start    = (state_reg == ST_FOUL);

        case (state_reg)
            ST_IDLE, ST_DONE, ST_FOUL: begin
                if (start) begin
                    state_next = ST_WAIT;
                    load_round = 1'b1;
                end
            end
            ST_WAIT: begin
                if (any_stop) begin
                    state_next     = ST_FOUL;
                    capture_winner = 1'b1;
                end else if (tick) begin
                    if (delay_reg == DELAY_W'(1)) state_next = ST_RUN;
                    else                          dec_delay  = 1'b1;
                end
            end
            ST_RUN: begin
                // A stop press beats a coincident tick, so the reported time never over-counts.
                if (any_stop) begin
                    state_next     = ST_DONE;
                    capture_winner = 1'b1;
                end else if (tick) begin
                    if (count_all_nines) begin
                        state_next   = ST_DONE;
                        set_overflow = 1'b1;
                    end else begin
                        count_inc = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            lfsr_reg     <= LFSR_SEED;
            div_reg      <= '0;
            delay_reg    <= '0;
            winner_reg   <= '0;
            overflow_reg <= 1'b0;
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            sync3_reg    <= '0;
        end else begin
            state_reg <= state_next;
            lfsr_reg  <= lfsr_step(lfsr_reg);
            sync1_reg <= stop;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;

            if (state_next != state_reg || tick) div_reg <= '0;
            else                                 div_reg <= div_reg + DIV_W'(1);

            if (load_round) begin
                delay_reg <= DELAY_W'(MIN_DELAY) + DELAY_W'(lfsr_reg[RAND_BITS-1:0]);
            end else if (dec_delay) begin
                delay_reg <= delay_reg - DELAY_W'(1);
            end

            if (load_round) begin
                winner_reg   <= '0;
                overflow_reg <= 1'b0;
            end else if (capture_winner) begin
                winner_reg <= lowest_index(stop_edge);
            end else if (set_overflow) begin
                winner_reg   <= '0;
                overflow_reg <= 1'b1;
            end
        end
    end

    bcd_counter_chain #(
        .DIGITS (DIGITS)
    ) u_count (
        .clk50M    (clk50M),
        .rst       (rst),
        .clear     (load_round),
        .inc       (count_inc),
        .value     (count_value),
        .all_nines (count_all_nines)
    );

    assign time_bcd = count_value;
    assign winner   = winner_reg;
    assign overflow = overflow_reg;

`ifdef REACTION_BEST_TIME_EN
    logic [4*DIGITS-1:0] best_reg;

    // Valid packed BCD orders identically to its binary value, so a plain compare is numeric.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            best_reg <= {DIGITS{4'd9}};
        end else if (state_reg == ST_RUN && capture_winner && count_value < best_reg) begin
            best_reg <= count_value;
        end
    end

    assign best_bcd = best_reg;
`endif

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Directed bench for reaction_timer_multi with a cycle-level behavioural model and literal checks.
module tb_reaction_timer_multi;

    localparam int M_IDLE = 0, M_WAIT = 1, M_RUN = 2, M_DONE = 3, M_FOUL = 4;

    typedef struct {
        int          mode;
        int          delay;
        int          count;
        int          best;
        int          win;
        bit          ovf;
        int          div;
        logic [15:0] lfsr;
        logic [1:0]  h1, h2, h3;
        bit          valid;
    } model_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] stop = 2'b00;
    logic       led_go, false_start, overflow, busy;
    logic [7:0] time_bcd;
    logic [0:0] winner;
`ifdef REACTION_BEST_TIME_EN
    logic [7:0] best_bcd;
`endif

    int     checks = 0;
    int     failures = 0;
    model_t m;

    always #5 clk = ~clk;

    reaction_timer_multi #(
        .DIGITS    (2),
        .PLAYERS   (2),
        .CLK_HZ    (1000),
        .TICK_HZ   (100),
        .MIN_DELAY (3),
        .RAND_BITS (2)
    ) dut (
        .clk50M      (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .led_go      (led_go),
        .time_bcd    (time_bcd),
        .winner      (winner),
        .false_start (false_start),
        .overflow    (overflow),
`ifdef REACTION_BEST_TIME_EN
        .best_bcd    (best_bcd),
`endif
        .busy        (busy)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Next model state from the rules: decimal count, tick every 10 cycles, stop seen 3 cycles late.
    function automatic model_t model_step(input model_t c, input logic r, input logic s, input logic [1:0] sp);
        model_t n;
        logic [1:0] ev;
        bit tk;
        n = c;
        if (r) begin
            n.mode = M_IDLE; n.delay = 0; n.count = 0; n.best = 99; n.win = 0; n.ovf = 0;
            n.div = 0; n.lfsr = 16'hACE1; n.h1 = 0; n.h2 = 0; n.h3 = 0; n.valid = 1;
            return n;
        end
        ev = c.h2 & ~c.h3;
        tk = (c.div == 9);
        case (c.mode)
            M_WAIT: begin
                if (ev != 0) begin
                    n.mode = M_FOUL; n.win = ev[0] ? 0 : 1;
                end else if (tk) begin
                    if (c.delay == 1) n.mode = M_RUN;
                    else              n.delay = c.delay - 1;
                end
            end
            M_RUN: begin
                if (ev != 0) begin
                    n.mode = M_DONE; n.win = ev[0] ? 0 : 1;
                    if (c.count < c.best) n.best = c.count;
                end else if (tk) begin
                    if (c.count == 99) begin
                        n.mode = M_DONE; n.ovf = 1; n.win = 0;
                    end else begin
                        n.count = c.count + 1;
                    end
                end
            end
            default: begin
                if (s) begin
                    n.mode = M_WAIT; n.delay = 3 + int'(c.lfsr[1:0]);
                    n.count = 0; n.ovf = 0; n.win = 0;
                end
            end
        endcase
        n.div  = (n.mode != c.mode || tk) ? 0 : c.div + 1;
        n.lfsr = c.lfsr[0] ? ((c.lfsr >> 1) ^ 16'hB400) : (c.lfsr >> 1);
        n.h1 = sp; n.h2 = c.h1; n.h3 = c.h2;
        return n;
    endfunction

    initial m.valid = 0;

    always @(posedge clk) m <= model_step(m, rst, start, stop);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m.valid) begin
            check("m_led_go",      32'(led_go),      32'(m.mode == M_RUN));
            check("m_busy",        32'(busy),        32'(m.mode == M_WAIT || m.mode == M_RUN));
            check("m_false_start", 32'(false_start), 32'(m.mode == M_FOUL));
            check("m_overflow",    32'(overflow),    32'(m.ovf));
            check("m_winner",      32'(winner),      32'(m.win));
            check("m_time_bcd",    32'(time_bcd),    32'(to_bcd(m.count)));
`ifdef REACTION_BEST_TIME_EN
            check("m_best_bcd",    32'(best_bcd),    32'(to_bcd(m.best)));
`endif
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_go(output int n);
        n = 0;
        while (led_go !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (led_go !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL wait_go_timeout got=%0d exp=<1000", n);
        end
    endtask

    initial begin
        int n, d;
        int rounds[3];
        int bests[3];
        rounds = '{7, 3, 5};
        bests  = '{7, 3, 3};

        repeat (3) @(negedge clk);
        check("rst_time", 32'(time_bcd), 32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_led", 32'(led_go), 32'h0);
        check("rst_winner", 32'(winner), 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: normal round, player 1 stops after 5 ticks
        pulse_start();
        d = m.delay;
        check("t1_busy", 32'(busy), 32'h1);
        wait_go(n);
        check("t1_wait_len", 32'(n), 32'(10 * d));
        check("t1_wait_range", 32'(n >= 30 && n <= 60), 32'h1);
        repeat (50) @(posedge clk);
        @(negedge clk); stop = 2'b10;
        repeat (2) @(negedge clk); stop = 2'b00;
        repeat (3) @(negedge clk);
        check("t1_time", 32'(time_bcd), 32'h05);
        check("t1_winner", 32'(winner), 32'h1);
        check("t1_led", 32'(led_go), 32'h0);

        // 2: false start by player 0
        pulse_start();
        repeat (4) @(negedge clk);
        stop = 2'b01;
        @(negedge clk); stop = 2'b00;
        @(negedge clk);
        check("t2_latency", 32'(false_start), 32'h0);
        @(negedge clk);
        check("t2_foul", 32'(false_start), 32'h1);
        check("t2_winner", 32'(winner), 32'h0);
        check("t2_time", 32'(time_bcd), 32'h00);

        // 3: saturation at 99
        pulse_start();
        wait_go(n);
        repeat (990) @(posedge clk);
        @(negedge clk);
        check("t3_time99", 32'(time_bcd), 32'h99);
        check("t3_no_ovf", 32'(overflow), 32'h0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t3_ovf", 32'(overflow), 32'h1);
        check("t3_hold", 32'(time_bcd), 32'h99);
        check("t3_winner", 32'(winner), 32'h0);
        check("t3_led", 32'(led_go), 32'h0);

        // 4: simultaneous stops aligned with a tick
        pulse_start();
        wait_go(n);
        repeat (27) @(posedge clk);
        @(negedge clk); stop = 2'b11;
        repeat (3) @(negedge clk);
        check("t4_winner", 32'(winner), 32'h0);
        check("t4_time", 32'(time_bcd), 32'h02);
        check("t4_led", 32'(led_go), 32'h0);
        stop = 2'b00;
        repeat (5) @(negedge clk);

        // 5: button held across WAIT and RUN entry, then re-pressed
        stop = 2'b10;
        repeat (5) @(negedge clk);
        pulse_start();
        wait_go(n);
        check("t5_no_foul", 32'(false_start), 32'h0);
        repeat (20) @(negedge clk);
        check("t5_still_run", 32'(led_go), 32'h1);
        stop = 2'b00;
        repeat (5) @(negedge clk);
        stop = 2'b10;
        repeat (3) @(negedge clk);
        check("t5_stopped", 32'(led_go), 32'h0);
        check("t5_winner", 32'(winner), 32'h1);
        check("t5_time", 32'(time_bcd), 32'h02);
        stop = 2'b00;

        // 6: best-time rounds after a fresh reset, then reset mid-run
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int r = 0; r < 3; r++) begin
            pulse_start();
            wait_go(n);
            repeat (10 * rounds[r]) @(posedge clk);
            @(negedge clk); stop = 2'b01;
            repeat (3) @(negedge clk);
            stop = 2'b00;
            check("t6_time", 32'(time_bcd), 32'(to_bcd(rounds[r])));
`ifdef REACTION_BEST_TIME_EN
            check("t6_best", 32'(best_bcd), 32'(to_bcd(bests[r])));
`endif
        end
        pulse_start();
        wait_go(n);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_led", 32'(led_go), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_time", 32'(time_bcd), 32'h00);
`ifdef REACTION_BEST_TIME_EN
        check("t6_rst_best", 32'(best_bcd), 32'h99);
`endif
        rst = 1'b0;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
